// File: rtl/param_controller_fsm.sv
// Fetch/decode/execute sequencer for the 16-bit datapath: PC, IR, register file,
// ALU and data-memory control, with memory ready handshake and a retired-instruction counter.
module param_controller_fsm #(
  parameter int IW   = 16,
  parameter int OPW  = 4,
  parameter int RAW  = 4,
  parameter int DAW  = 8,
  parameter int CNTW = 16
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [IW-1:0]   i_instr,
  input  logic            i_dready,
  input  logic            i_alu_zero,
  input  logic            i_run,
  output logic            o_pc_clr,
  output logic            o_pc_up,
  output logic            o_pc_ld,
  output logic [DAW-1:0]  o_pc_ld_addr,
  output logic            o_ir_ld,
  output logic [DAW-1:0]  o_daddr,
  output logic            o_dread,
  output logic            o_dwrite,
  output logic            o_rf_write_enable,
  output logic [1:0]      o_rf_select,
  output logic [RAW-1:0]  o_rf_write_addr,
  output logic [RAW-1:0]  o_rf_a_read_addr,
  output logic [RAW-1:0]  o_rf_b_read_addr,
  output logic [2:0]      o_alu_select,
  output logic [DAW-1:0]  o_imm,
  output logic [3:0]      o_state,
  output logic            o_halted,
  output logic            o_illegal_op,
  output logic [CNTW-1:0] o_retired_count
);

  // state | meaning:  INIT 8 clear PC | FETCH F load IR | DECODE C dispatch | NOOP 0
  // STORE 1 write, wait ready | LOAD_REQ 2 read, wait ready | LOAD_WB 6 write back
  // ADD 3 | SUB 4 | HALT 5 wait for run | LDI 7 | JMP 9 | JZ A branch on ALU zero
  typedef enum logic [3:0] {
    S_NOOP     = 4'h0,
    S_STORE    = 4'h1,
    S_LOAD_REQ = 4'h2,
    S_ADD      = 4'h3,
    S_SUB      = 4'h4,
    S_HALT     = 4'h5,
    S_LOAD_WB  = 4'h6,
    S_LDI      = 4'h7,
    S_INIT     = 4'h8,
    S_JMP      = 4'h9,
    S_JZ       = 4'hA,
    S_DECODE   = 4'hC,
    S_FETCH    = 4'hF
  } state_t;

  localparam logic [OPW-1:0] OP_NOOP  = OPW'(0);
  localparam logic [OPW-1:0] OP_STORE = OPW'(1);
  localparam logic [OPW-1:0] OP_LOAD  = OPW'(2);
  localparam logic [OPW-1:0] OP_ADD   = OPW'(3);
  localparam logic [OPW-1:0] OP_SUB   = OPW'(4);
  localparam logic [OPW-1:0] OP_HALT  = OPW'(5);
  localparam logic [OPW-1:0] OP_LDI   = OPW'(6);
  localparam logic [OPW-1:0] OP_JMP   = OPW'(7);
  localparam logic [OPW-1:0] OP_JZ    = OPW'(8);

  state_t          r_state;
  logic [CNTW-1:0] r_retired;

  logic [OPW-1:0] w_op;
  logic [RAW-1:0] w_ra, w_rb, w_rd, w_jz_ra;
  logic [DAW-1:0] w_maddr, w_saddr;

  assign w_op    = i_instr[IW-1 -: OPW];
  assign w_ra    = i_instr[3*RAW-1 -: RAW];
  assign w_rb    = i_instr[2*RAW-1 -: RAW];
  assign w_rd    = i_instr[RAW-1:0];
  assign w_maddr = i_instr[DAW+RAW-1:RAW];
  assign w_saddr = i_instr[DAW-1:0];
  assign w_jz_ra = i_instr[DAW+RAW-1 -: RAW];

  // An instruction retires on the edge leaving its execute state; HALT retires on entry.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_INIT;
      r_retired <= '0;
    end else begin
      case (r_state)
        S_INIT:  r_state <= S_FETCH;
        S_FETCH: r_state <= S_DECODE;
        S_DECODE: begin
          case (w_op)
            OP_STORE: r_state <= S_STORE;
            OP_LOAD:  r_state <= S_LOAD_REQ;
            OP_ADD:   r_state <= S_ADD;
            OP_SUB:   r_state <= S_SUB;
            OP_HALT: begin
              r_state   <= S_HALT;
              r_retired <= r_retired + CNTW'(1);
            end
            OP_LDI:   r_state <= S_LDI;
            OP_JMP:   r_state <= S_JMP;
            OP_JZ:    r_state <= S_JZ;
            default:  r_state <= S_NOOP;
          endcase
        end
        S_NOOP, S_ADD, S_SUB, S_LDI, S_JMP, S_JZ, S_LOAD_WB: begin
          r_state   <= S_FETCH;
          r_retired <= r_retired + CNTW'(1);
        end
        S_STORE: begin
          if (i_dready) begin
            r_state   <= S_FETCH;
            r_retired <= r_retired + CNTW'(1);
          end
        end
        S_LOAD_REQ: begin
          if (i_dready) r_state <= S_LOAD_WB;
        end
        S_HALT: begin
          if (i_run) r_state <= S_FETCH;
        end
        default: r_state <= S_INIT;
      endcase
    end
  end

  always_comb begin
    o_pc_clr          = 1'b0;
    o_pc_up           = 1'b0;
    o_pc_ld           = 1'b0;
    o_pc_ld_addr      = '0;
    o_ir_ld           = 1'b0;
    o_daddr           = '0;
    o_dread           = 1'b0;
    o_dwrite          = 1'b0;
    o_rf_write_enable = 1'b0;
    o_rf_select       = 2'd0;
    o_rf_write_addr   = '0;
    o_rf_a_read_addr  = '0;
    o_rf_b_read_addr  = '0;
    o_alu_select      = 3'b000;
    o_imm             = '0;
    o_halted          = 1'b0;
    o_illegal_op      = 1'b0;
    case (r_state)
      S_INIT:   o_pc_clr = 1'b1;
      S_FETCH: begin
        o_pc_up = 1'b1;
        o_ir_ld = 1'b1;
      end
      S_DECODE: o_illegal_op = (w_op > OP_JZ);
      S_STORE: begin
        o_daddr          = w_saddr;
        o_rf_a_read_addr = w_ra;
        o_dwrite         = 1'b1;
      end
      S_LOAD_REQ: begin
        o_daddr = w_maddr;
        o_dread = 1'b1;
      end
      S_LOAD_WB: begin
        o_daddr           = w_maddr;
        o_rf_select       = 2'd1;
        o_rf_write_addr   = w_rd;
        o_rf_write_enable = 1'b1;
      end
      S_ADD, S_SUB: begin
        o_rf_a_read_addr  = w_ra;
        o_rf_b_read_addr  = w_rb;
        o_rf_write_addr   = w_rd;
        o_rf_write_enable = 1'b1;
        o_alu_select      = (r_state == S_ADD) ? 3'b001 : 3'b010;
      end
      S_LDI: begin
        o_imm             = w_maddr;
        o_rf_select       = 2'd2;
        o_rf_write_addr   = w_rd;
        o_rf_write_enable = 1'b1;
      end
      S_JMP: begin
        o_pc_ld      = 1'b1;
        o_pc_ld_addr = w_saddr;
      end
      S_JZ: begin
        o_rf_a_read_addr = w_jz_ra;
        o_pc_ld_addr     = w_saddr;
        o_pc_ld          = i_alu_zero;
      end
      S_HALT:   o_halted = 1'b1;
      default: ;
    endcase
  end

  assign o_state         = r_state;
  assign o_retired_count = r_retired;

endmodule

// File: tb/tb_param_controller_fsm.sv
// Directed bench for param_controller_fsm: each cycle's expected outputs are queued
// as the stimulus is driven and compared against the DUT on the following falling edge.
module tb_param_controller_fsm;

  logic        clk, rst, dready, alu_zero, run;
  logic [15:0] instr;

  logic        pc_clr, pc_up, pc_ld, ir_ld, dread, dwrite, rf_we, halted, illegal;
  logic [7:0]  pc_ld_addr, daddr, imm;
  logic [1:0]  rf_sel;
  logic [3:0]  rf_wa, rf_ra, rf_rb, state;
  logic [2:0]  alu_sel;
  logic [15:0] cnt;

  param_controller_fsm dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_instr           (instr),
    .i_dready          (dready),
    .i_alu_zero        (alu_zero),
    .i_run             (run),
    .o_pc_clr          (pc_clr),
    .o_pc_up           (pc_up),
    .o_pc_ld           (pc_ld),
    .o_pc_ld_addr      (pc_ld_addr),
    .o_ir_ld           (ir_ld),
    .o_daddr           (daddr),
    .o_dread           (dread),
    .o_dwrite          (dwrite),
    .o_rf_write_enable (rf_we),
    .o_rf_select       (rf_sel),
    .o_rf_write_addr   (rf_wa),
    .o_rf_a_read_addr  (rf_ra),
    .o_rf_b_read_addr  (rf_rb),
    .o_alu_select      (alu_sel),
    .o_imm             (imm),
    .o_state           (state),
    .o_halted          (halted),
    .o_illegal_op      (illegal),
    .o_retired_count   (cnt)
  );

  typedef struct packed {
    logic [3:0]  state;
    logic        pc_clr, pc_up, pc_ld;
    logic [7:0]  pc_ld_addr;
    logic        ir_ld;
    logic [7:0]  daddr;
    logic        dread, dwrite, rf_we;
    logic [1:0]  rf_sel;
    logic [3:0]  rf_wa, rf_ra, rf_rb;
    logic [2:0]  alu_sel;
    logic [7:0]  imm;
    logic        halted, illegal;
    logic [15:0] cnt;
  } obs_t;

  typedef struct {
    string tag;
    obs_t  v;
  } sb_t;

  sb_t  sb[$];
  sb_t  item;
  obs_t obs, e;
  int   n_err = 0;
  int   n_checks = 0;

  always_comb begin
    obs            = '0;
    obs.state      = state;
    obs.pc_clr     = pc_clr;
    obs.pc_up      = pc_up;
    obs.pc_ld      = pc_ld;
    obs.pc_ld_addr = pc_ld_addr;
    obs.ir_ld      = ir_ld;
    obs.daddr      = daddr;
    obs.dread      = dread;
    obs.dwrite     = dwrite;
    obs.rf_we      = rf_we;
    obs.rf_sel     = rf_sel;
    obs.rf_wa      = rf_wa;
    obs.rf_ra      = rf_ra;
    obs.rf_rb      = rf_rb;
    obs.alu_sel    = alu_sel;
    obs.imm        = imm;
    obs.halted     = halted;
    obs.illegal    = illegal;
    obs.cnt        = cnt;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      item = sb.pop_front();
      n_checks++;
      assert (obs === item.v)
      else begin
        n_err++;
        $error("FAIL %s: observed %h expected %h", item.tag, obs, item.v);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input obs_t v);
    sb.push_back('{tag: tag, v: v});
  endtask

  function automatic obs_t ex(input logic [3:0] st, input logic [15:0] c);
    obs_t r;
    r       = '0;
    r.state = st;
    r.cnt   = c;
    return r;
  endfunction

  task automatic chk_init(input string tag, input logic [15:0] c);
    obs_t r;
    r = ex(4'h8, c);
    r.pc_clr = 1'b1;
    push(tag, r);
  endtask

  task automatic chk_fetch(input string tag, input logic [15:0] c);
    obs_t r;
    r = ex(4'hF, c);
    r.pc_up = 1'b1;
    r.ir_ld = 1'b1;
    push(tag, r);
  endtask

  task automatic chk_decode(input string tag, input logic [15:0] c);
    push(tag, ex(4'hC, c));
  endtask

  initial begin
    rst = 1'b1; instr = 16'h0000; dready = 1'b0; alu_zero = 1'b0; run = 1'b0;

    // reset held for two edges, then NOOP
    next_cycle(); chk_init("rst_hold", 0);
    next_cycle(); rst = 1'b0; chk_init("rst_init", 0);
    next_cycle(); chk_fetch("noop_fetch", 0);
    next_cycle(); chk_decode("noop_decode", 0);
    next_cycle(); push("noop_exec", ex(4'h0, 0));

    // ADD r3 = r1 + r2
    next_cycle(); instr = 16'h3123; chk_fetch("add_fetch", 1);
    next_cycle(); chk_decode("add_decode", 1);
    next_cycle(); e = ex(4'h3, 1); e.rf_ra = 4'd1; e.rf_rb = 4'd2; e.rf_wa = 4'd3;
    e.alu_sel = 3'b001; e.rf_we = 1'b1; push("add_exec", e);

    // LOAD r7 <- mem[A5] with two wait cycles
    next_cycle(); instr = 16'h2A57; chk_fetch("load_fetch", 2);
    next_cycle(); chk_decode("load_decode", 2);
    e = ex(4'h2, 2); e.daddr = 8'hA5; e.dread = 1'b1;
    next_cycle(); push("load_wait1", e);
    next_cycle(); push("load_wait2", e);
    next_cycle(); dready = 1'b1; push("load_ready", e);
    next_cycle(); e = ex(4'h6, 2); e.daddr = 8'hA5; e.rf_sel = 2'd1; e.rf_wa = 4'd7;
    e.rf_we = 1'b1; push("load_wb", e);

    // JZ taken then not taken; register field is Instr[11:8]
    next_cycle(); dready = 1'b0; instr = 16'h8340; alu_zero = 1'b1; chk_fetch("jz1_fetch", 3);
    next_cycle(); chk_decode("jz1_decode", 3);
    next_cycle(); e = ex(4'hA, 3); e.rf_ra = 4'd3; e.pc_ld_addr = 8'h40; e.pc_ld = 1'b1;
    push("jz_taken", e);
    next_cycle(); alu_zero = 1'b0; chk_fetch("jz2_fetch", 4);
    next_cycle(); chk_decode("jz2_decode", 4);
    next_cycle(); e = ex(4'hA, 4); e.rf_ra = 4'd3; e.pc_ld_addr = 8'h40; push("jz_not_taken", e);

    // JMP 55
    next_cycle(); instr = 16'h7055; chk_fetch("jmp_fetch", 5);
    next_cycle(); chk_decode("jmp_decode", 5);
    next_cycle(); e = ex(4'h9, 5); e.pc_ld = 1'b1; e.pc_ld_addr = 8'h55; push("jmp_exec", e);

    // LDI r9 <- C3
    next_cycle(); instr = 16'h6C39; chk_fetch("ldi_fetch", 6);
    next_cycle(); chk_decode("ldi_decode", 6);
    next_cycle(); e = ex(4'h7, 6); e.imm = 8'hC3; e.rf_sel = 2'd2; e.rf_wa = 4'd9;
    e.rf_we = 1'b1; push("ldi_exec", e);

    // SUB rC = rA - rB
    next_cycle(); instr = 16'h4ABC; chk_fetch("sub_fetch", 7);
    next_cycle(); chk_decode("sub_decode", 7);
    next_cycle(); e = ex(4'h4, 7); e.rf_ra = 4'hA; e.rf_rb = 4'hB; e.rf_wa = 4'hC;
    e.alu_sel = 3'b010; e.rf_we = 1'b1; push("sub_exec", e);

    // STORE with ready already high: no wait cycle
    next_cycle(); instr = 16'h1312; dready = 1'b1; chk_fetch("st_fetch", 8);
    next_cycle(); chk_decode("st_decode", 8);
    next_cycle(); e = ex(4'h1, 8); e.daddr = 8'h12; e.rf_ra = 4'd3; e.dwrite = 1'b1;
    push("st_nowait", e);

    // HALT: Run high on the entering edge must not exit
    next_cycle(); dready = 1'b0; instr = 16'h5000; run = 1'b1; chk_fetch("halt_fetch", 9);
    next_cycle(); chk_decode("halt_decode", 9);
    for (int i = 0; i < 10; i++) begin
      next_cycle(); run = 1'b0; e = ex(4'h5, 10); e.halted = 1'b1;
      push($sformatf("halt_wait%0d", i), e);
    end
    next_cycle(); run = 1'b1; e = ex(4'h5, 10); e.halted = 1'b1; push("halt_exit", e);

    // illegal opcode falls through to NOOP
    next_cycle(); run = 1'b0; instr = 16'hF000; chk_fetch("halt_resume_fetch", 10);
    next_cycle(); e = ex(4'hC, 10); e.illegal = 1'b1; push("illegal_decode", e);
    next_cycle(); push("illegal_noop", ex(4'h0, 10));

    // reset while STORE is waiting for ready
    next_cycle(); instr = 16'h1312; chk_fetch("st2_fetch", 11);
    next_cycle(); chk_decode("st2_decode", 11);
    e = ex(4'h1, 11); e.daddr = 8'h12; e.rf_ra = 4'd3; e.dwrite = 1'b1;
    next_cycle(); push("st2_wait", e);
    next_cycle(); rst = 1'b1; push("st2_wait_rst", e);
    next_cycle(); rst = 1'b0; chk_init("st2_after_rst", 0);
    next_cycle(); chk_fetch("restart_fetch", 0);

    @(negedge clk);
    #1;
    n_checks++;
    assert (sb.size() == 0)
    else begin
      n_err++;
      $error("FAIL sb_drain: observed %0d pending expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
